// File: rtl/dac_cmd_seq_if.sv
// Command and SPI-master handshake bundle for the DAC command sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface dac_cmd_seq_if #(
   parameter int CODE_WIDTH = 16,
   parameter int SPI_WIDTH  = 24
);
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic [3:0]            cmd_op_i;
   logic [3:0]            cmd_ch_i;
   logic [CODE_WIDTH-1:0] cmd_code_i;
   logic [SPI_WIDTH-1:0]  spi_data_o;
   logic                  spi_wre_o;
   logic                  spi_rdy_i;

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_ch_i, cmd_code_i, spi_rdy_i,
      output cmd_ready_o, spi_data_o, spi_wre_o
   );

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_ch_i, cmd_code_i, spi_rdy_i,
      input  cmd_ready_o, spi_data_o, spi_wre_o
   );
endinterface

// File: rtl/dac_cmd_seq.sv
// DAC command sequencer: buffers write commands in a FIFO, sends a fixed init frame after
// reset, then packs each command into one SPI frame with a single-frame-outstanding handshake.
module dac_cmd_seq #(
   parameter int                   CODE_WIDTH = 16,
   parameter int                   SPI_WIDTH  = 24,
   parameter int                   FIFO_DEPTH = 4,
   parameter logic [SPI_WIDTH-1:0] INIT_WORD  = 24'h80_0001
) (
   input  logic         clk_i,
   input  logic         arst_ni,
   dac_cmd_seq_if.slave bus,
   output logic         init_done_o,
   output logic         busy_o,
   output logic [15:0]  frames_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   generate
      if (SPI_WIDTH != 8 + CODE_WIDTH) begin : g_bad_width
         $error("dac_cmd_seq: SPI_WIDTH must equal 8 + CODE_WIDTH");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("dac_cmd_seq: FIFO_DEPTH must be a power of 2 and at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_STROBE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t               state;
   logic [SPI_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic [SPI_WIDTH-1:0] packed_cmd;
   logic [SPI_WIDTH-1:0] spi_data_q;
   logic                 wre_q;
   logic                 init_done_q;
   logic                 init_frame_q;
   logic [15:0]          frames_q;

   // The extra pointer bit separates full from empty when the index bits coincide.
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign push       = bus.cmd_valid_i && !full;
   assign pop        = (state == S_IDLE) && !empty && bus.spi_rdy_i;
   assign packed_cmd = {bus.cmd_op_i, bus.cmd_ch_i, bus.cmd_code_i};

   assign bus.cmd_ready_o = !full;
   assign bus.spi_data_o  = spi_data_q;
   assign bus.spi_wre_o   = wre_q;
   assign init_done_o     = init_done_q;
   assign frames_o        = frames_q;
   assign busy_o          = (state != S_IDLE) || !empty;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= packed_cmd;
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // spi_data_q only changes on a load, so the master sees a stable frame through WAIT_*.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state        <= S_INIT;
         spi_data_q   <= '0;
         wre_q        <= 1'b0;
         init_done_q  <= 1'b0;
         init_frame_q <= 1'b0;
         frames_q     <= '0;
      end else begin
         wre_q <= 1'b0;
         case (state)
            S_INIT: begin
               if (bus.spi_rdy_i) begin
                  spi_data_q   <= INIT_WORD;
                  wre_q        <= 1'b1;
                  init_frame_q <= 1'b1;
                  state        <= S_STROBE;
               end
            end
            S_IDLE: begin
               if (pop) begin
                  spi_data_q   <= fifo_mem[rd_ptr[PTR_W-1:0]];
                  wre_q        <= 1'b1;
                  init_frame_q <= 1'b0;
                  state        <= S_STROBE;
               end
            end
            S_STROBE: begin
               state <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (!bus.spi_rdy_i) begin
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (bus.spi_rdy_i) begin
                  frames_q <= frames_q + 16'd1;
                  if (init_frame_q) begin
                     init_done_q <= 1'b1;
                  end
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dac_cmd_seq.sv
// Self-checking bench for dac_cmd_seq: directed commands feed an expected-frame queue that a
// monitor drains on every write strobe, alongside directed checks of status outputs.
module tb_dac_cmd_seq;

   localparam int          CW        = 16;
   localparam int          SW        = 24;
   localparam logic [23:0] INIT_WORD = 24'h80_0001;

   logic        clk    = 1'b0;
   logic        arst_n = 1'b0;
   logic        init_done;
   logic        busy;
   logic [15:0] frames;

   dac_cmd_seq_if #(.CODE_WIDTH(CW), .SPI_WIDTH(SW)) bus ();

   dac_cmd_seq #(
      .CODE_WIDTH(CW),
      .SPI_WIDTH (SW),
      .FIFO_DEPTH(4),
      .INIT_WORD (INIT_WORD)
   ) dut (
      .clk_i      (clk),
      .arst_ni    (arst_n),
      .bus        (bus),
      .init_done_o(init_done),
      .busy_o     (busy),
      .frames_o   (frames)
   );

   always #5 clk = ~clk;

   int          checks       = 0;
   int          failures     = 0;
   int          cyc          = 0;
   int          stall        = 30;
   int          last_wre_cyc = -1;
   int          wre_count    = 0;
   logic        prev_wre     = 1'b0;
   logic [23:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=event", name);
   endtask

   // Scoreboard monitor: every strobe must carry the oldest outstanding expected frame.
   always @(negedge clk) begin
      if (arst_n && bus.spi_wre_o) begin
         last_wre_cyc = cyc;
         wre_count++;
         check_output("wre_rdy_low", {31'd0, bus.spi_rdy_i}, 32'd1);
         check_output("wre_one_cycle", {31'd0, prev_wre}, 32'd0);
         if (exp_q.size() == 0) begin
            timeout_fail("frame_unexpected");
         end else begin
            check_output("frame_data", {8'd0, bus.spi_data_o}, {8'd0, exp_q.pop_front()});
         end
      end
      prev_wre = arst_n && bus.spi_wre_o;
   end

   // SPI master model: drops rdy one cycle after a strobe and holds it low for 'stall' cycles.
   initial begin
      bus.spi_rdy_i = 1'b1;
      forever begin
         @(posedge clk);
         if (bus.spi_wre_o === 1'b1) begin
            #1 bus.spi_rdy_i = 1'b0;
            repeat (stall) @(posedge clk);
            #1 bus.spi_rdy_i = 1'b1;
         end
      end
   end

   task automatic apply_stimulus(input logic [3:0] op, input logic [3:0] ch,
                                 input logic [15:0] code, output int acc_cyc);
      int n = 0;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = op;
      bus.cmd_ch_i    = ch;
      bus.cmd_code_i  = code;
      while (!bus.cmd_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         timeout_fail("push_ready");
         bus.cmd_valid_i = 1'b0;
         acc_cyc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         exp_q.push_back({op, ch, code});
         bus.cmd_valid_i = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (!(!busy && bus.spi_rdy_i && !bus.spi_wre_o) && n < max) begin
         @(negedge clk);
         n++;
      end
      if (n >= max) timeout_fail(name);
   endtask

   task automatic wait_init(input string name, input int max);
      int n = 0;
      while (!init_done && n < max) begin
         @(negedge clk);
         n++;
      end
      if (n >= max) timeout_fail(name);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      arst_n = 1'b0;
      exp_q.delete();
      #1;
      check_output("rst_wre", {31'd0, bus.spi_wre_o}, 32'd0);
      check_output("rst_data", {8'd0, bus.spi_data_o}, 32'd0);
      check_output("rst_init_done", {31'd0, init_done}, 32'd0);
      check_output("rst_frames", {16'd0, frames}, 32'd0);
      check_output("rst_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      arst_n = 1'b1;
      exp_q.push_back(INIT_WORD);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc;
      int n;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = '0;
      bus.cmd_ch_i    = '0;
      bus.cmd_code_i  = '0;

      // Reset and init frame
      repeat (2) @(negedge clk);
      apply_reset();
      check_output("ready_after_reset", {31'd0, bus.cmd_ready_o}, 32'd1);
      wait_init("init_done_wait", 200);
      check_output("init_frames", {16'd0, frames}, 32'd1);
      check_output("init_wre_count", wre_count, 32'd1);

      // Single command, latency and packing
      stall = 5;
      wait_idle("idle_before_single", 200);
      apply_stimulus(4'h3, 4'h1, 16'hABCD, acc);
      check_output("busy_after_accept", {31'd0, busy}, 32'd1);
      wait_idle("idle_after_single", 200);
      check_output("single_latency", last_wre_cyc - acc, 32'd1);
      check_output("single_data_held", {8'd0, bus.spi_data_o}, 32'h0031ABCD);
      check_output("single_frames", {16'd0, frames}, 32'd2);

      // Six back-to-back commands against a stalled master
      stall = 8;
      apply_stimulus(4'h1, 4'h0, 16'h0001, acc);
      apply_stimulus(4'h2, 4'h1, 16'h1111, acc);
      apply_stimulus(4'h3, 4'h2, 16'h2222, acc);
      apply_stimulus(4'h4, 4'h3, 16'h3333, acc);
      apply_stimulus(4'h5, 4'h4, 16'h4444, acc);
      check_output("ready_full", {31'd0, bus.cmd_ready_o}, 32'd0);
      apply_stimulus(4'h6, 4'h5, 16'hFFFF, acc);
      wait_idle("idle_after_burst", 1000);
      check_output("burst_frames", {16'd0, frames}, 32'd8);
      check_output("burst_drained", exp_q.size(), 32'd0);

      // Reset while a frame is in WAIT_DONE with two commands queued
      stall = 30;
      apply_stimulus(4'h7, 4'h6, 16'h0A0A, acc);
      apply_stimulus(4'h8, 4'h7, 16'h0B0B, acc);
      apply_stimulus(4'h9, 4'h8, 16'h0C0C, acc);
      n = 0;
      while (bus.spi_rdy_i && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout_fail("rdy_drop_wait");
      repeat (3) @(negedge clk);
      apply_reset();
      wait_init("reinit_wait", 300);
      check_output("reinit_frames", {16'd0, frames}, 32'd1);
      wait_idle("idle_after_reinit", 300);
      check_output("flush_frames", {16'd0, frames}, 32'd1);
      check_output("flush_queue", exp_q.size(), 32'd0);

      // Command pushed while the sequencer is still in INIT
      stall = 5;
      apply_reset();
      apply_stimulus(4'h5, 4'h2, 16'h1234, acc);
      n = 0;
      while (!(bus.spi_wre_o && bus.spi_data_o == 24'h521234) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) timeout_fail("init_cmd_wre_wait");
      check_output("init_before_cmd", {31'd0, init_done}, 32'd1);
      wait_idle("idle_after_init_cmd", 200);
      check_output("init_cmd_frames", {16'd0, frames}, 32'd2);

      // Frame counter wrap
      @(negedge clk);
      force dut.frames_q = 16'hFFFF;
      #1;
      release dut.frames_q;
      @(negedge clk);
      check_output("frames_preload", {16'd0, frames}, 32'h0000FFFF);
      apply_stimulus(4'hC, 4'hD, 16'h5A5A, acc);
      wait_idle("idle_after_wrap", 200);
      check_output("frames_wrap", {16'd0, frames}, 32'd0);

      repeat (5) @(negedge clk);
      check_output("final_queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
